// File: rtl/key_edge_capture.sv
// key_edge_capture: debounced key inputs with press-edge capture, a
// masked level interrupt and a saturating press counter, exposed through
// a four-word Avalon-MM slave with fixed read latency of one cycle.

module key_edge_capture #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic             clk_50,
  input  logic             reset,
  input  logic [WIDTH-1:0] keys_in,
  input  logic [1:0]       avs_address,
  input  logic             avs_read,
  output logic [31:0]      avs_readdata,
  input  logic             avs_write,
  input  logic [31:0]      avs_writedata,
  output logic             irq
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [WIDTH-1:0] POLARITY = {WIDTH{ACTIVE_LOW}};

  localparam logic [1:0] ADDR_DATA  = 2'd0;
  localparam logic [1:0] ADDR_MASK  = 2'd1;
  localparam logic [1:0] ADDR_EDGE  = 2'd2;
  localparam logic [1:0] ADDR_COUNT = 2'd3;

  logic [WIDTH-1:0] sync1_q, sync1_d;
  logic [WIDTH-1:0] sync2_q, sync2_d;
  logic [WIDTH-1:0] deb_q, deb_d;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] edges_q, edges_d;
  logic [15:0]      count_q, count_d;
  logic [31:0]      readdata_q, readdata_d;
  logic             irq_q, irq_d;

  logic [WIDTH-1:0] press;
  logic [4:0]       press_cnt;
  logic [16:0]      count_sum;
  logic [31:0]      rd_word;
  logic             wr_mask, wr_edge, wr_count;
  logic             unused_wdata;

  // Upper write-data bits carry no state; fold them so they count as consumed.
  assign unused_wdata = ^avs_writedata;

  // Two-flop synchronizer; the polarity fold sits in front of the first
  // stage so a cleared synchronizer always means "released".
  always_comb begin
    sync1_d = keys_in ^ POLARITY;
    sync2_d = sync1_q;
  end

  // Per-key debouncer: STABLE while sync matches deb (counter held at 0),
  // PENDING while it differs; a long enough disagreement flips deb.
  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          deb_d[i] = ~deb_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // A press is the cycle in which a debounced level is about to rise.
  always_comb begin
    press     = deb_d & ~deb_q;
    press_cnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      press_cnt = press_cnt + 5'(press[i]);
    end
  end

  // Register next-state: edge set beats same-cycle clear, count saturates,
  // and a count clear coinciding with presses keeps this cycle's presses.
  always_comb begin
    wr_mask   = avs_write && (avs_address == ADDR_MASK);
    wr_edge   = avs_write && (avs_address == ADDR_EDGE);
    wr_count  = avs_write && (avs_address == ADDR_COUNT);

    mask_d    = wr_mask ? avs_writedata[WIDTH-1:0] : mask_q;
    edges_d   = (edges_q & ~(wr_edge ? avs_writedata[WIDTH-1:0] : '0)) | press;

    count_sum = {1'b0, count_q} + {12'b0, press_cnt};
    if (wr_count) begin
      count_d = {11'b0, press_cnt};
    end else if (count_sum[16]) begin
      count_d = 16'hFFFF;
    end else begin
      count_d = count_sum[15:0];
    end

    irq_d = |(edges_q & mask_q);
  end

  // Read mux uses current register contents, so a read paired with a write
  // returns the pre-write value; readdata only changes on a read.
  always_comb begin
    rd_word = '0;
    case (avs_address)
      ADDR_DATA:  rd_word[WIDTH-1:0] = deb_q;
      ADDR_MASK:  rd_word[WIDTH-1:0] = mask_q;
      ADDR_EDGE:  rd_word[WIDTH-1:0] = edges_q;
      ADDR_COUNT: rd_word[15:0]      = count_q;
      default:    rd_word            = '0;
    endcase
    readdata_d = avs_read ? rd_word : readdata_q;
  end

  // All state, cleared asynchronously by reset.
  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
      mask_q     <= '0;
      edges_q    <= '0;
      count_q    <= '0;
      readdata_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      deb_q      <= deb_d;
      cnt_q      <= cnt_d;
      mask_q     <= mask_d;
      edges_q    <= edges_d;
      count_q    <= count_d;
      readdata_q <= readdata_d;
      irq_q      <= irq_d;
    end
  end

  assign avs_readdata = readdata_q;
  assign irq          = irq_q;

endmodule

// File: tb/tb_key_edge_capture.sv
// Testbench for key_edge_capture: a small-debounce instance driven by
// directed and random traffic against a cycle-level reference model, plus
// a wide, fast-debounce active-high instance that drives the press counter
// into saturation.

module tb_key_edge_capture;

  localparam int WIDTH = 4;
  localparam int DEB   = 4;

  logic        clk_50 = 1'b0;
  logic        reset  = 1'b0;
  logic [3:0]  keys_in = 4'hF;
  logic [1:0]  avs_address = 2'd0;
  logic        avs_read = 1'b0;
  logic        avs_write = 1'b0;
  logic [31:0] avs_writedata = 32'd0;
  logic [31:0] avs_readdata;
  logic        irq;

  logic        s_reset = 1'b0;
  logic [15:0] s_keys = 16'h0;
  logic [1:0]  s_address = 2'd0;
  logic        s_read = 1'b0;
  logic        s_write = 1'b0;
  logic [31:0] s_writedata = 32'd0;
  logic [31:0] s_readdata;
  logic        s_irq;

  int checks = 0;
  int passes = 0;
  bit sat_done = 1'b0;

  // Reference model state: what each register holds after the latest edge.
  logic [3:0]  m_s1, m_s2, m_deb, m_mask, m_edge;
  int          m_run [4];
  int          m_count;
  logic        m_irq;
  logic [31:0] exp_q [$];

  always #5 clk_50 = ~clk_50;

  key_edge_capture #(.WIDTH(WIDTH), .DEBOUNCE_CYCLES(DEB), .ACTIVE_LOW(1'b1)) dut (
    .clk_50(clk_50), .reset(reset), .keys_in(keys_in),
    .avs_address(avs_address), .avs_read(avs_read), .avs_readdata(avs_readdata),
    .avs_write(avs_write), .avs_writedata(avs_writedata), .irq(irq)
  );

  key_edge_capture #(.WIDTH(16), .DEBOUNCE_CYCLES(2), .ACTIVE_LOW(1'b0)) dut_sat (
    .clk_50(clk_50), .reset(s_reset), .keys_in(s_keys),
    .avs_address(s_address), .avs_read(s_read), .avs_readdata(s_readdata),
    .avs_write(s_write), .avs_writedata(s_writedata), .irq(s_irq)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
  endtask

  function automatic logic [31:0] model_reg(input logic [1:0] a);
    case (a)
      2'd0:    return {28'h0, m_deb};
      2'd1:    return {28'h0, m_mask};
      2'd2:    return {28'h0, m_edge};
      default: return {16'h0, m_count[15:0]};
    endcase
  endfunction

  task automatic model_clear();
    m_s1 = '0; m_s2 = '0; m_deb = '0; m_mask = '0; m_edge = '0;
    m_count = 0; m_irq = 1'b0;
    for (int i = 0; i < 4; i++) m_run[i] = 0;
  endtask

  // One clock edge of the register-level behaviour, using pre-edge state.
  task automatic model_step(input logic [3:0] pins, input logic [1:0] a,
                            input logic rd, input logic wr, input logic [31:0] wd);
    logic [3:0] nd;
    logic [3:0] pr;
    int np;
    if (rd) exp_q.push_back(model_reg(a));
    nd = m_deb;
    for (int i = 0; i < 4; i++) begin
      if (m_s2[i] != m_deb[i]) begin
        m_run[i]++;
        if (m_run[i] == DEB) begin
          nd[i] = ~m_deb[i];
          m_run[i] = 0;
        end
      end else begin
        m_run[i] = 0;
      end
    end
    pr = nd & ~m_deb;
    np = $countones(pr);
    m_irq = |(m_edge & m_mask);
    if (wr && a == 2'd2) m_edge = m_edge & ~wd[3:0];
    m_edge = m_edge | pr;
    if (wr && a == 2'd1) m_mask = wd[3:0];
    if (wr && a == 2'd3) m_count = np;
    else m_count = (m_count + np > 65535) ? 65535 : m_count + np;
    m_deb = nd;
    m_s2  = m_s1;
    m_s1  = ~pins;
  endtask

  task automatic tick();
    logic [3:0]  p;
    logic [1:0]  a;
    logic        rd, wr;
    logic [31:0] wd;
    p = keys_in; a = avs_address; rd = avs_read; wr = avs_write; wd = avs_writedata;
    @(posedge clk_50);
    model_step(p, a, rd, wr, wd);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] pins, input logic [1:0] a,
                               input logic rd, input logic wr, input logic [31:0] wd);
    keys_in = pins; avs_address = a; avs_read = rd; avs_write = wr; avs_writedata = wd;
    tick();
    avs_read = 1'b0;
    avs_write = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(keys_in, 2'd0, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic reg_write(input logic [1:0] a, input logic [31:0] d);
    applyStimulus(keys_in, a, 1'b0, 1'b1, d);
  endtask

  task automatic read_expect(input string name, input logic [1:0] a, input logic [31:0] v);
    applyStimulus(keys_in, a, 1'b1, 1'b0, 32'd0);
    #3;
    checkOutput(name, avs_readdata, v);
  endtask

  task automatic check_irq(input string name, input logic v);
    #3;
    checkOutput(name, {31'b0, irq}, {31'b0, v});
  endtask

  // Asynchronous reset mid-cycle; outputs must clear without waiting for a clock.
  task automatic do_reset();
    avs_read = 1'b0;
    avs_write = 1'b0;
    #2;
    reset = 1'b1;
    model_clear();
    exp_q.delete();
    #1;
    checkOutput("reset_readdata", avs_readdata, 32'd0);
    checkOutput("reset_irq", {31'b0, irq}, 32'd0);
    repeat (2) @(posedge clk_50);
    #3;
    reset = 1'b0;
  endtask

  // Monitor: compares readdata on the cycle after each read and irq every cycle.
  initial begin
    bit rd_seen;
    forever begin
      @(posedge clk_50);
      rd_seen = avs_read && !reset;
      #2;
      if (rd_seen) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("[TB] FAIL readdata_unexpected: got 0x%08h, expected no pending read", avs_readdata);
        end else begin
          checkOutput("readdata", avs_readdata, exp_q.pop_front());
        end
      end
      checkOutput("irq", {31'b0, irq}, {31'b0, m_irq});
    end
  end

  // Main stimulus for the four-key instance.
  initial begin
    logic [3:0]  p;
    logic        rd, wr;
    logic [1:0]  a;
    logic [31:0] wd;

    do_reset();
    read_expect("rst_data", 2'd0, 32'd0);
    read_expect("rst_mask", 2'd1, 32'd0);
    read_expect("rst_edge", 2'd2, 32'd0);
    read_expect("rst_count", 2'd3, 32'd0);

    // Key 0 pressed and held: level appears 2+4 edges after the pin change.
    keys_in = 4'hE;
    for (int k = 1; k <= 8; k++)
      read_expect($sformatf("press_timing_%0d", k), 2'd0, (k >= 7) ? 32'd1 : 32'd0);
    read_expect("edge_after_press", 2'd2, 32'd1);
    read_expect("count_after_press", 2'd3, 32'd1);
    keys_in = 4'hF;
    idle(8);
    read_expect("data_released", 2'd0, 32'd0);
    read_expect("count_no_release_evt", 2'd3, 32'd1);
    reg_write(2'd2, 32'hF);
    reg_write(2'd3, 32'd0);
    read_expect("edge_cleared", 2'd2, 32'd0);
    read_expect("count_cleared", 2'd3, 32'd0);
    reg_write(2'd0, 32'hF);
    read_expect("data_ignores_write", 2'd0, 32'd0);

    // Three-cycle glitch on key 1 is rejected.
    keys_in = 4'hD;
    idle(3);
    keys_in = 4'hF;
    idle(8);
    read_expect("glitch_data", 2'd0, 32'd0);
    read_expect("glitch_edge", 2'd2, 32'd0);
    read_expect("glitch_count", 2'd3, 32'd0);

    // Masked interrupt on key 2, cleared by write-1; key 3 stays masked.
    reg_write(2'd1, 32'h4);
    keys_in = 4'hB;
    idle(6);
    check_irq("irq_not_yet", 1'b0);
    idle(1);
    check_irq("irq_set", 1'b1);
    read_expect("edge_key2", 2'd2, 32'h4);
    reg_write(2'd2, 32'h4);
    check_irq("irq_hold_after_clear", 1'b1);
    idle(1);
    check_irq("irq_cleared", 1'b0);
    keys_in = 4'hF;
    idle(8);
    keys_in = 4'h7;
    idle(8);
    check_irq("irq_masked", 1'b0);
    read_expect("edge_key3", 2'd2, 32'h8);
    keys_in = 4'hF;
    idle(8);

    // Clear of EDGE[0] lands on the very edge the key 0 press sets it.
    reg_write(2'd2, 32'hF);
    keys_in = 4'hE;
    idle(5);
    applyStimulus(keys_in, 2'd2, 1'b0, 1'b1, 32'h1);
    read_expect("edge_set_wins", 2'd2, 32'h1);
    keys_in = 4'hF;
    idle(8);

    // Read and write of MASK together: read returns the old value.
    applyStimulus(keys_in, 2'd1, 1'b1, 1'b1, 32'h3);
    #3;
    checkOutput("rw_same_cycle", avs_readdata, 32'h4);
    read_expect("mask_written", 2'd1, 32'h3);
    read_expect("mask_upper_zero", 2'd1, 32'h3);

    // Reset two cycles into a pending press with the key held throughout.
    reg_write(2'd1, 32'hF);
    read_expect("mask_all", 2'd1, 32'hF);
    keys_in = 4'hE;
    idle(4);
    check_irq("irq_pre_reset", 1'b1);
    do_reset();
    for (int k = 1; k <= 8; k++)
      read_expect($sformatf("post_reset_timing_%0d", k), 2'd0, (k >= 7) ? 32'd1 : 32'd0);
    read_expect("post_reset_count", 2'd3, 32'd1);
    read_expect("post_reset_edge", 2'd2, 32'd1);
    read_expect("post_reset_mask", 2'd1, 32'd0);
    keys_in = 4'hF;
    idle(8);

    // Random traffic: slowly wandering keys plus random bus accesses.
    for (int c = 0; c < 1500; c++) begin
      p = keys_in;
      for (int i = 0; i < 4; i++)
        if ($urandom_range(0, 9) == 0) p[i] = ~p[i];
      rd = 1'($urandom_range(0, 1));
      wr = ($urandom_range(0, 3) == 0);
      a  = 2'($urandom_range(0, 3));
      wd = $urandom;
      applyStimulus(p, a, rd, wr, wd);
    end
    keys_in = 4'hF;
    idle(12);

    for (int i = 0; i < 60000 && !sat_done; i++) @(posedge clk_50);
    if (!sat_done) begin
      checks++;
      $display("[TB] FAIL sat_timeout: got not done, expected done within 60000 cycles");
    end
    checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

  // Wide instance: press all keys together repeatedly to saturate COUNT.
  task automatic sat_press(input logic [15:0] m);
    s_keys = m;
    repeat (5) @(posedge clk_50);
    #1;
    s_keys = 16'h0;
    repeat (5) @(posedge clk_50);
    #1;
  endtask

  task automatic sat_read(input string name, input logic [1:0] a, input logic [31:0] v);
    s_address = a;
    s_read = 1'b1;
    @(posedge clk_50);
    #1;
    s_read = 1'b0;
    #2;
    checkOutput(name, s_readdata, v);
  endtask

  initial begin
    #3;
    s_reset = 1'b1;
    repeat (2) @(posedge clk_50);
    #1;
    s_reset = 1'b0;
    for (int n = 0; n < 4095; n++) sat_press(16'hFFFF);
    sat_press(16'h3FFF);
    sat_read("sat_fffe", 2'd3, 32'h0000FFFE);
    sat_press(16'h0003);
    sat_read("sat_ffff", 2'd3, 32'h0000FFFF);
    sat_press(16'h0003);
    sat_read("sat_stays", 2'd3, 32'h0000FFFF);
    sat_read("sat_edge_all", 2'd2, 32'h0000FFFF);
    sat_read("sat_data_released", 2'd0, 32'd0);
    s_address = 2'd3;
    s_writedata = 32'd0;
    s_write = 1'b1;
    @(posedge clk_50);
    #1;
    s_write = 1'b0;
    sat_read("sat_count_cleared", 2'd3, 32'd0);
    s_keys = 16'h0001;
    repeat (5) @(posedge clk_50);
    #1;
    sat_read("sat_active_high_data", 2'd0, 32'h1);
    s_keys = 16'h0;
    repeat (5) @(posedge clk_50);
    #1;
    sat_read("sat_count_one", 2'd3, 32'd1);
    checkOutput("sat_irq_unmasked_off", {31'b0, s_irq}, 32'd0);
    sat_done = 1'b1;
  end

endmodule

// File: doc/key_edge_capture.md
KEY_EDGE_CAPTURE -- requirements
Module: key_edge_capture

Interface
REQ-001 Parameter WIDTH, default 4: number of key inputs, 1..16.
REQ-002 Parameter DEBOUNCE_CYCLES, default 500000: stable cycles required to accept a new key level (10 ms at 50 MHz), minimum 2.
REQ-003 Parameter ACTIVE_LOW, default 1: 1 means a key reads 0 when pressed.
REQ-004 clk_50  input  1  sole clock; all state is on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 keys_in  input  WIDTH  raw asynchronous key pins.
REQ-007 avs_address  input  2  register select (word address).
REQ-008 avs_read  input  1  read strobe.
REQ-009 avs_readdata  output  32  read data.
REQ-010 avs_write  input  1  write strobe.
REQ-011 avs_writedata  input  32  write data.
REQ-012 irq  output  1  level interrupt, active high.

Function
REQ-013 keys_in SHALL pass through a 2-flop synchronizer per bit before any other use.
REQ-014 After the synchronizer, keys SHALL be normalized to pressed=1 (inverted when ACTIVE_LOW=1).
REQ-015 Each bit SHALL have its own debouncer with a counter of width ceil(log2(DEBOUNCE_CYCLES+1)) and a debounced level deb[i]; states STABLE (sync==deb, counter held at 0) and PENDING (sync!=deb, counter increments).
REQ-016 The debouncer SHALL move from PENDING to STABLE with the counter cleared on any cycle where sync returns to deb (glitch rejected).
REQ-017 When the counter reaches DEBOUNCE_CYCLES-1 in PENDING, deb[i] SHALL toggle on the next edge, and the counter SHALL clear.
REQ-018 A press event on bit i SHALL be the single-cycle 0->1 transition of deb[i]; a release (1->0) SHALL NOT be an event.
REQ-019 Register 0 DATA: bits [WIDTH-1:0]=deb, remaining bits 0, read-only; writes SHALL be ignored.
REQ-020 Register 1 MASK: bits [WIDTH-1:0] read/write, remaining bits read 0.
REQ-021 Register 2 EDGE: bit i SHALL set on a press event on bit i; a write SHALL clear every bit whose writedata bit is 1.
REQ-022 On a cycle with a press event and a write-1-clear to the same EDGE bit, the set SHALL win.
REQ-023 Register 3 COUNT: 16-bit count of press events, incremented by the number of press events in that cycle (0..WIDTH), saturating at 0xFFFF; any write SHALL clear it to 0; an increment in the same cycle as a clear SHALL yield the increment value.
REQ-024 Reads SHALL have fixed latency 1: avs_readdata SHALL be valid the cycle after avs_read and SHALL hold its value until the next read; reads SHALL have no side effects.
REQ-025 irq SHALL be registered: irq = OR(EDGE & MASK) as of the previous cycle, 1 cycle after the EDGE/MASK change.
REQ-026 avs_read and avs_write asserted together SHALL perform both; readdata SHALL reflect pre-write contents.

Reset
REQ-027 Reset asserted SHALL immediately clear the synchronizer flops, deb, debounce counters, MASK, EDGE, COUNT, avs_readdata and irq to 0, independent of clk_50.
REQ-028 Reset mid-debounce SHALL discard the pending transition; after release a key already pressed SHALL need a full DEBOUNCE_CYCLES of stability, then produce one press event.
REQ-029 Reset deassertion is synchronized externally; the block SHALL run normally from the first edge after release.

Verification (DEBOUNCE_CYCLES=4, WIDTH=4, ACTIVE_LOW=1)
REQ-030 keys_in[0] driven 0 and held -> DATA reads 0x1, EDGE 0x1, COUNT 1; deb[0] rises 2 (sync) + 4 cycles after the pin change.
REQ-031 keys_in[1] pulsed 0 for 3 cycles, then 1 -> DATA, EDGE, COUNT stay 0.
REQ-032 MASK=0x4, press key2 -> irq=1 one cycle after EDGE[2] sets; write EDGE=0x4 -> irq=0 two cycles later; press key3 with MASK=0x4 -> irq stays 0.
REQ-033 Write EDGE=0x1 on the exact cycle of a key0 press event -> EDGE[0] reads 1.
REQ-034 COUNT forced to 0xFFFE by presses, then keys 0 and 1 pressed in the same cycle -> COUNT=0xFFFF and stays there on further presses; write COUNT -> 0.
REQ-035 Reset asserted 2 cycles into PENDING with the key held -> all registers 0 at once; after release DATA=0x1 exactly 2+4 cycles later and COUNT=1.
